// File: rtl/axis_video_to_rgb.sv
// axis_video_to_rgb
//   Accepts a 48-bit AXI4-Stream video stream (six 8-bit components per beat),
//   checks the line/frame structure, and presents each beat on a parallel
//   RGB port with every component widened to 10 bits.
//
//   Ports
//     clk_i, reset_n_i       clock, asynchronous active-low reset
//     s_axis_video_*         AXI4-Stream slave. TUSER = start of frame,
//                            TLAST = end of line. TKEEP/TSTRB/TDEST/TID are
//                            accepted but not used.
//     rgb_data_o[119:0]      component k in [10k+9:10k]; bits [119:60] are 0
//     rgb_data_valid_o[5:0]  all ones while a word is transferred, else 0
//     rgb_ready_i            sink accepts the presented word this cycle
//     sof_o, eol_o           first-of-frame / last-of-line, qualified by valid
//     err_o[2:0]             one-cycle pulses, one cycle after the beat:
//                            [0] early TLAST, [1] missing TLAST,
//                            [2] TUSER in mid-frame

// Per-component widening: 8-bit component placed in the MSBs of a 10-bit
// slot, LSBs zero.
module axis_video_to_rgb_lane (
  input  logic [7:0] comp,
  output logic [9:0] pix
);
  assign pix = {comp, 2'b00};
endmodule

module axis_video_to_rgb #(
  parameter int LINE_BEATS  = 3840,
  parameter int FRAME_LINES = 2610,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [47:0]  s_axis_video_TDATA,
  input  logic [5:0]   s_axis_video_TKEEP,
  input  logic [5:0]   s_axis_video_TSTRB,
  input  logic [0:0]   s_axis_video_TDEST,
  input  logic [0:0]   s_axis_video_TID,
  input  logic         s_axis_video_TUSER,
  input  logic         s_axis_video_TLAST,
  input  logic         s_axis_video_TVALID,
  output logic         s_axis_video_TREADY,
  output logic [119:0] rgb_data_o,
  output logic [5:0]   rgb_data_valid_o,
  input  logic         rgb_ready_i,
  output logic         sof_o,
  output logic         eol_o,
  output logic [2:0]   err_o
);
  localparam int NUM_LANES = 6;
  localparam int VEC_W     = 8;
  localparam int PIX_W     = 10;
  localparam int BW        = (LINE_BEATS  > 1) ? $clog2(LINE_BEATS)  : 1;
  localparam int LW        = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int PW        = (FIFO_DEPTH  > 1) ? $clog2(FIFO_DEPTH)  : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_BEATS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_LINES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic                            sof;
    logic                            eol;
  } entry_t;

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LW-1:0] line_q, line_d;
  logic [2:0]    err_q, err_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full, hs, push, pop, eol_c, tready;
  entry_t        wr_entry, head;
  entry_t        mem [FIFO_DEPTH];
  logic [NUM_LANES-1:0][PIX_W-1:0] pix;

  // Sideband fields carry no meaning for this sink.
  logic unused_sideband;
  assign unused_sideband = ^{s_axis_video_TKEEP, s_axis_video_TSTRB,
                             s_axis_video_TDEST, s_axis_video_TID};

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Ready is a function of registered state only (no path from TVALID).
  // The FIFO is always empty in WAIT_SOF, since only reset returns there.
  assign tready = reset_n_i & ((state_q == WAIT_SOF) | ~full);
  assign s_axis_video_TREADY = tready;
  assign hs = s_axis_video_TVALID & tready;

  // ---------------------------------------------------------------- framing
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= WAIT_SOF;
      beat_q  <= '0;
      line_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    line_d        = line_q;
    err_d         = '0;
    push          = 1'b0;
    eol_c         = s_axis_video_TLAST | (beat_q == BEAT_LAST);
    wr_entry.data = s_axis_video_TDATA;
    wr_entry.sof  = s_axis_video_TUSER;
    wr_entry.eol  = eol_c;
    case (state_q)
      WAIT_SOF: begin
        // Beats before the first start-of-frame are consumed and dropped.
        if (hs && s_axis_video_TUSER) begin
          push    = 1'b1;
          state_d = ACTIVE;
          beat_d  = (beat_q == BEAT_LAST) ? '0 : BW'(1);
          line_d  = '0;
        end
      end
      ACTIVE: begin
        if (hs) begin
          push = 1'b1;
          if (s_axis_video_TUSER && !(beat_q == '0 && line_q == '0)) begin
            // Stray start-of-frame: resynchronise on it.
            err_d[2] = 1'b1;
            beat_d   = BW'(1);
            line_d   = '0;
          end else if (eol_c) begin
            err_d[0] = s_axis_video_TLAST & (beat_q != BEAT_LAST);
            err_d[1] = ~s_axis_video_TLAST;
            beat_d   = '0;
            line_d   = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign err_o = err_q;

  // ------------------------------------------------------------ output FIFO
  assign pop = ~empty & rgb_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the head is only observed when non-empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  assign head = mem[rd_ptr_q];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axis_video_to_rgb_lane u_lane (
      .comp (head.data[g]),
      .pix  (pix[g])
    );
  end

  // Data is forced to zero when empty so that reset and idle read as 0.
  assign rgb_data_o       = empty ? '0 : {{(120 - NUM_LANES*PIX_W){1'b0}}, pix};
  assign rgb_data_valid_o = {NUM_LANES{pop}};
  assign sof_o            = pop & head.sof;
  assign eol_o            = pop & head.eol;
endmodule

// File: tb/tb_axis_video_to_rgb.sv
module tb_axis_video_to_rgb;
  localparam int LB = 4;
  localparam int FL = 3;
  localparam int FD = 4;

  typedef struct packed {
    logic [47:0] data;
    logic        user;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [119:0] data;
    logic [5:0]   vld;
    logic         sof;
    logic         eol;
  } word_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [47:0]  tdata = '0;
  logic [5:0]   tkeep = '1;
  logic [5:0]   tstrb = '1;
  logic         tdest = 1'b0;
  logic         tid = 1'b0;
  logic         tuser = 1'b0;
  logic         tlast = 1'b0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [119:0] rgb_data;
  logic [5:0]   rgb_valid;
  logic         rgb_ready = 1'b0;
  logic         sof, eol;
  logic [2:0]   err;

  int errors = 0;
  int checks = 0;
  int spur = 0;
  bit rnd_rdy = 0;
  bit prev_hs = 0;

  beat_t      acc_q[$];
  word_t      out_q[$];
  logic [2:0] errobs_q[$];
  word_t      exp_out_q[$];
  logic [2:0] exp_err_q[$];
  bit         m_sync;
  int         m_pos;

  axis_video_to_rgb #(.LINE_BEATS(LB), .FRAME_LINES(FL), .FIFO_DEPTH(FD)) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .s_axis_video_TDATA  (tdata),
    .s_axis_video_TKEEP  (tkeep),
    .s_axis_video_TSTRB  (tstrb),
    .s_axis_video_TDEST  (tdest),
    .s_axis_video_TID    (tid),
    .s_axis_video_TUSER  (tuser),
    .s_axis_video_TLAST  (tlast),
    .s_axis_video_TVALID (tvalid),
    .s_axis_video_TREADY (tready),
    .rgb_data_o          (rgb_data),
    .rgb_data_valid_o    (rgb_valid),
    .rgb_ready_i         (rgb_ready),
    .sof_o               (sof),
    .eol_o               (eol),
    .err_o               (err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: samples mid-cycle; records accepted beats, delivered words,
  // and the err_o value seen the cycle after each accepted beat.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_hs = 0;
    end else begin
      if (prev_hs) errobs_q.push_back(err);
      else if (err !== 3'b000) spur++;
      prev_hs = tvalid && tready;
      if (prev_hs) acc_q.push_back({tdata, tuser, tlast});
      if (rgb_valid !== 6'h00) out_q.push_back({rgb_data, rgb_valid, sof, eol});
      else if (sof !== 1'b0 || eol !== 1'b0) spur++;
    end
  end

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [119:0] expand(input logic [47:0] d);
    logic [119:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r = r | (120'(d[8*k +: 8]) << (10*k + 2));
    return r;
  endfunction

  // Reference model: tracks the position inside the frame as one number
  // (line*LB + beat) and derives outputs/errors for each accepted beat.
  task automatic model_run();
    beat_t      b;
    int         bi;
    logic [2:0] e;
    logic       el;
    exp_out_q.delete();
    exp_err_q.delete();
    for (int i = 0; i < acc_q.size(); i++) begin
      b  = acc_q[i];
      bi = m_pos % LB;
      e  = 3'b000;
      if (!m_sync) begin
        if (b.user) begin
          m_sync = 1;
          exp_out_q.push_back({expand(b.data), 6'h3F, 1'b1, b.last || (LB == 1)});
          m_pos = 1;
        end
      end else if (b.user && m_pos != 0) begin
        e = 3'b100;
        exp_out_q.push_back({expand(b.data), 6'h3F, 1'b1, b.last || (bi == LB-1)});
        m_pos = 1;
      end else begin
        el = b.last || (bi == LB-1);
        if (b.last && bi < LB-1) e = 3'b001;
        else if (!b.last && bi == LB-1) e = 3'b010;
        exp_out_q.push_back({expand(b.data), 6'h3F, b.user, el});
        if (el) m_pos = ((m_pos / LB + 1) % FL) * LB;
        else m_pos++;
      end
      exp_err_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    tvalid = 0; tuser = 0; tlast = 0; rgb_ready = 0; rnd_rdy = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    acc_q.delete(); out_q.delete(); errobs_q.delete();
    m_sync = 0; m_pos = 0; spur = 0;
    #1 reset_n = 1;
  endtask

  task automatic send(input logic [47:0] d, input logic u, input logic l);
    bit ok;
    int n;
    tdata = d; tuser = u; tlast = l; tvalid = 1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk); ok = tready;
      @(posedge clk); #1; n++;
      if (rnd_rdy) rgb_ready = 1'($urandom_range(0, 1));
    end
    tvalid = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: tready stayed 0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_rdy) rgb_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input int n);
    int k;
    rnd_rdy = 0; rgb_ready = 1; k = 0;
    while (out_q.size() < n && k < 300) begin
      @(posedge clk); #1; k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_pattern(input int n, input logic [15:0] us, input logic [15:0] ls);
    for (int i = 0; i < n; i++) send(rnd48(), us[i], ls[i]);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    tvalid = 1; tdata = rnd48(); rgb_ready = 1;
    #1 reset_n = 0;
    #2;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", tready); end
    checks++; if (rgb_valid !== 6'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", rgb_valid); end
    checks++; if (rgb_data !== 120'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rgb_data); end
    checks++; if ({sof, eol} !== 2'b00) begin errors++; $display("FAIL reset_sof_eol: got %b want 00", {sof, eol}); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", err); end
    tvalid = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL wait_sof_tready: got %b want 1", tready); end
  endtask

  task automatic test_frame();
    do_reset();
    rgb_ready = 1;
    send(rnd48(), 0, 0);
    send(rnd48(), 0, 0);
    for (int i = 0; i < 12; i++) send(rnd48(), i == 0, (i % 4) == 3);
    model_run();
    drain(12);
    checks++; if (acc_q.size() != 14) begin errors++; $display("FAIL frame_accepted: got %0d want 14", acc_q.size()); end
    checks++; if (out_q.size() != 12) begin errors++; $display("FAIL frame_count: got %0d want 12", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 12; i++) begin
      checks++;
      if (out_q[i].data !== expand(acc_q[i+2].data) || out_q[i].sof !== (i == 0) ||
          out_q[i].eol !== ((i % 4) == 3)) begin
        errors++; $display("FAIL frame_word%0d: got %h want data %h sof %0d eol %0d",
                           i, out_q[i], expand(acc_q[i+2].data), i == 0, (i % 4) == 3);
      end
    end
    for (int i = 0; i < errobs_q.size(); i++) begin
      checks++; if (errobs_q[i] !== 3'b000) begin errors++; $display("FAIL frame_err%0d: got %b want 000", i, errobs_q[i]); end
    end
    for (int i = 0; i < out_q.size() && i < exp_out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_out_q[i]) begin errors++; $display("FAIL frame_model%0d: got %h want %h", i, out_q[i], exp_out_q[i]); end
    end
    checks++; if (spur != 0) begin errors++; $display("FAIL frame_spurious: got %0d want 0", spur); end
  endtask

  task automatic test_unpack();
    do_reset();
    rgb_ready = 1;
    send(48'h0102030405FF, 1, 0);
    drain(1);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL unpack_count: got %0d want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++;
      if (out_q[0].data !== {60'h0, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h3FC}) begin
        errors++; $display("FAIL unpack_data: got %h want %h", out_q[0].data,
                           {60'h0, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h3FC});
      end
      checks++; if (out_q[0].vld !== 6'h3F || out_q[0].sof !== 1'b1) begin
        errors++; $display("FAIL unpack_flags: got vld %h sof %b want 3f 1", out_q[0].vld, out_q[0].sof);
      end
    end
  endtask

  task automatic test_early_tlast();
    logic [15:0] eolx;
    do_reset();
    rgb_ready = 1;
    send_pattern(10, 16'h0001, 16'h0228);
    drain(10);
    eolx = 16'h0228;
    checks++; if (out_q.size() != 10 || errobs_q.size() != 10) begin
      errors++; $display("FAIL early_count: got %0d/%0d want 10/10", out_q.size(), errobs_q.size());
    end
    for (int i = 0; i < out_q.size() && i < errobs_q.size() && i < 10; i++) begin
      checks++;
      if (errobs_q[i] !== ((i == 5) ? 3'b001 : 3'b000) || out_q[i].eol !== eolx[i]) begin
        errors++; $display("FAIL early_beat%0d: got err %b eol %b want err %b eol %b",
                           i, errobs_q[i], out_q[i].eol, (i == 5) ? 3'b001 : 3'b000, eolx[i]);
      end
    end
  endtask

  task automatic test_missing_tlast();
    logic [15:0] eolx;
    do_reset();
    rgb_ready = 1;
    send_pattern(8, 16'h0001, 16'h0080);
    drain(8);
    eolx = 16'h0088;
    checks++; if (out_q.size() != 8 || errobs_q.size() != 8) begin
      errors++; $display("FAIL missing_count: got %0d/%0d want 8/8", out_q.size(), errobs_q.size());
    end
    for (int i = 0; i < out_q.size() && i < errobs_q.size() && i < 8; i++) begin
      checks++;
      if (errobs_q[i] !== ((i == 3) ? 3'b010 : 3'b000) || out_q[i].eol !== eolx[i]) begin
        errors++; $display("FAIL missing_beat%0d: got err %b eol %b want err %b eol %b",
                           i, errobs_q[i], out_q[i].eol, (i == 3) ? 3'b010 : 3'b000, eolx[i]);
      end
    end
  endtask

  task automatic test_unexpected_tuser();
    logic [15:0] sofx, eolx;
    do_reset();
    rgb_ready = 1;
    send_pattern(9, 16'h0021, 16'h0108);
    drain(9);
    sofx = 16'h0021;
    eolx = 16'h0108;
    checks++; if (out_q.size() != 9 || errobs_q.size() != 9) begin
      errors++; $display("FAIL tuser_count: got %0d/%0d want 9/9", out_q.size(), errobs_q.size());
    end
    for (int i = 0; i < out_q.size() && i < errobs_q.size() && i < 9; i++) begin
      checks++;
      if (errobs_q[i] !== ((i == 5) ? 3'b100 : 3'b000) || out_q[i].sof !== sofx[i] ||
          out_q[i].eol !== eolx[i]) begin
        errors++; $display("FAIL tuser_beat%0d: got err %b sof %b eol %b want err %b sof %b eol %b",
                           i, errobs_q[i], out_q[i].sof, out_q[i].eol,
                           (i == 5) ? 3'b100 : 3'b000, sofx[i], eolx[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [47:0] d [12];
    int i;
    bit ok;
    do_reset();
    for (int k = 0; k < 12; k++) d[k] = rnd48();
    rgb_ready = 0; i = 0;
    tdata = d[0]; tuser = 1; tlast = 0; tvalid = 1;
    repeat (10) begin
      @(negedge clk); ok = tready;
      @(posedge clk); #1;
      if (ok) begin i++; tdata = d[i]; tuser = 0; tlast = ((i % 4) == 3); end
    end
    checks++; if (i != FD) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", i, FD); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL bp_tready: got %b want 0", tready); end
    tvalid = 0;
    rgb_ready = 1;
    for (int k = i; k < 12; k++) send(d[k], k == 0, (k % 4) == 3);
    model_run();
    drain(12);
    checks++; if (out_q.size() != 12) begin errors++; $display("FAIL bp_count: got %0d want 12", out_q.size()); end
    for (int k = 0; k < out_q.size() && k < 12; k++) begin
      checks++; if (out_q[k].data !== expand(d[k])) begin
        errors++; $display("FAIL bp_order%0d: got %h want %h", k, out_q[k].data, expand(d[k]));
      end
    end
    for (int k = 0; k < out_q.size() && k < exp_out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out_q[k]) begin errors++; $display("FAIL bp_model%0d: got %h want %h", k, out_q[k], exp_out_q[k]); end
    end
  endtask

  task automatic test_midframe_reset();
    logic [47:0] d0;
    do_reset();
    rgb_ready = 0;
    send(rnd48(), 1, 0);
    send(rnd48(), 0, 0);
    send(rnd48(), 0, 0);
    #2 reset_n = 0;
    rgb_ready = 1;
    #1;
    checks++; if (rgb_valid !== 6'h00 || rgb_data !== 120'h0 || tready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got vld %h data %h tready %b want 00 0 0", rgb_valid, rgb_data, tready);
    end
    @(posedge clk);
    acc_q.delete(); out_q.delete(); errobs_q.delete();
    m_sync = 0; m_pos = 0; spur = 0;
    #1 reset_n = 1;
    rgb_ready = 1;
    send(rnd48(), 0, 1);
    d0 = rnd48();
    send(d0, 1, 0);
    for (int i = 1; i < 4; i++) send(rnd48(), 0, i == 3);
    model_run();
    drain(4);
    checks++; if (out_q.size() != 4 || exp_out_q.size() != 4) begin
      errors++; $display("FAIL midreset_count: got %0d want 4", out_q.size());
    end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0].data !== expand(d0) || out_q[0].sof !== 1'b1) begin
        errors++; $display("FAIL midreset_first: got %h sof %b want %h sof 1", out_q[0].data, out_q[0].sof, expand(d0));
      end
    end
    for (int i = 0; i < out_q.size() && i < exp_out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_out_q[i]) begin errors++; $display("FAIL midreset_model%0d: got %h want %h", i, out_q[i], exp_out_q[i]); end
    end
  endtask

  task automatic test_random();
    logic u, l;
    do_reset();
    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      u = (i == 3) || (i > 3 && $urandom_range(0, 19) == 0);
      if (((i - 3) % 4) == 3) l = ($urandom_range(0, 7) != 0);
      else l = ($urandom_range(0, 9) == 0);
      send(rnd48(), u, l);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    model_run();
    drain(exp_out_q.size());
    checks++; if (out_q.size() != exp_out_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", out_q.size(), exp_out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_out_q[i]) begin errors++; $display("FAIL rand_word%0d: got %h want %h", i, out_q[i], exp_out_q[i]); end
    end
    checks++; if (errobs_q.size() != exp_err_q.size()) begin
      errors++; $display("FAIL rand_err_count: got %0d want %0d", errobs_q.size(), exp_err_q.size());
    end
    for (int i = 0; i < errobs_q.size() && i < exp_err_q.size(); i++) begin
      checks++; if (errobs_q[i] !== exp_err_q[i]) begin errors++; $display("FAIL rand_err%0d: got %b want %b", i, errobs_q[i], exp_err_q[i]); end
    end
    checks++; if (spur != 0) begin errors++; $display("FAIL rand_spurious: got %0d want 0", spur); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_unpack();
    test_early_tlast();
    test_missing_tlast();
    test_unexpected_tuser();
    test_back_pressure();
    test_midframe_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_video_to_rgb.md
AXIS_VIDEO_TO_RGB -- requirements
Module: axis_video_to_rgb

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 3840, meaning accepted beats per video line.
REQ-002 SHALL have parameter FRAME_LINES, default 2610, meaning lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port s_axis_video_TDATA, input, 48, meaning six 8-bit components; byte k = TDATA[8k+7:8k].
REQ-007 SHALL have ports s_axis_video_TKEEP/TSTRB, input, 6 each, meaning byte qualifiers, ignored.
REQ-008 SHALL have ports s_axis_video_TDEST/TID, input, 1 each, meaning routing, ignored.
REQ-009 SHALL have ports s_axis_video_TUSER (start of frame), s_axis_video_TLAST (end of line) and s_axis_video_TVALID, input, 1 each.
REQ-010 SHALL have port s_axis_video_TREADY, output, 1, meaning the block accepts a beat.
REQ-011 SHALL have port rgb_data_o, output, 120, meaning unpacked pixel data.
REQ-012 SHALL have port rgb_data_valid_o, output, 6, meaning per-component valid.
REQ-013 SHALL have port rgb_ready_i, input, 1, meaning the downstream sink can take data this cycle.
REQ-014 SHALL have ports sof_o and eol_o, output, 1 each, meaning the current output word is first of frame / last of line.
REQ-015 SHALL have port err_o, output, 3, meaning one-cycle error pulses: [0] early TLAST, [1] missing TLAST, [2] unexpected TUSER.

Function
REQ-016 SHALL count a handshake when TVALID and TREADY are both 1 on a rising edge.
REQ-017 SHALL implement state machine WAIT_SOF/ACTIVE; reset state is WAIT_SOF.
REQ-018 SHALL, in WAIT_SOF, drive TREADY=1 and drop every beat without TUSER (no push, no error).
REQ-019 SHALL, in WAIT_SOF, on a beat with TUSER, push it, set beat_cnt=1, line_cnt=0 and go to ACTIVE.
REQ-020 SHALL, in ACTIVE, drive TREADY = not FIFO-full, with full taken from registered state only.
REQ-021 SHALL keep beat_cnt in range 0..LINE_BEATS-1 and line_cnt in range 0..FRAME_LINES-1, advancing only on handshake.
REQ-022 SHALL, on an ACTIVE beat with TLAST and beat_cnt<LINE_BEATS-1, pulse err_o[0] and treat the beat as end of line.
REQ-023 SHALL, on an ACTIVE beat with beat_cnt==LINE_BEATS-1 and no TLAST, pulse err_o[1] and still end the line.
REQ-024 SHALL, at end of line, set beat_cnt=0 and increment line_cnt; line_cnt wraps from FRAME_LINES-1 to 0.
REQ-025 SHALL, on an ACTIVE beat with TUSER while not (beat_cnt==0 and line_cnt==0), pulse err_o[2], push the beat as frame start and set beat_cnt=1, line_cnt=0.
REQ-026 SHALL register err_o pulses one cycle after the offending handshake; err_o SHALL be 0 otherwise.
REQ-027 SHALL give each FIFO entry the fields {TDATA, sof=TUSER, eol = TLAST or beat_cnt==LINE_BEATS-1}.
REQ-028 SHALL, for FIFO read and write, advance FIFO pointers modulo FIFO_DEPTH and track occupancy 0..FIFO_DEPTH.
REQ-029 SHALL allow push and pop in the same cycle, with occupancy unchanged.
REQ-030 SHALL NOT push when full, because TREADY is 0.
REQ-031 SHALL make output visible when the FIFO is non-empty; a word is popped when rgb_ready_i=1.
REQ-032 SHALL drive rgb_data_valid_o=6'b111111 when non-empty and rgb_ready_i=1, and 0 otherwise.
REQ-033 SHALL, for each k=0..5, set rgb_data_o[10k+9:10k+2]=byte k and rgb_data_o[10k+1:10k]=2'b00, with rgb_data_o[119:60]=0.
REQ-034 SHALL drive rgb_data_o/sof_o/eol_o from the FIFO head, and gate sof_o/eol_o with the rgb_data_valid_o condition.
REQ-035 SHALL have a minimum latency of 1 cycle, i.e. a beat accepted at edge N is visible after edge N.
REQ-036 SHALL sustain 1 beat/cycle throughput while rgb_ready_i=1.

Reset
REQ-037 SHALL, while reset_n_i=0, asynchronously set state=WAIT_SOF, FIFO empty, counters 0, err_o=0, rgb_data_valid_o=0, sof_o=eol_o=0, rgb_data_o=0 and TREADY=0.
REQ-038 SHALL, on reset mid-frame, discard FIFO contents and resynchronise on the next TUSER.

Verification (LINE_BEATS=4, FRAME_LINES=3, FIFO_DEPTH=4)
REQ-039 SHALL cover: 2 beats without TUSER, then a full 12-beat frame, rgb_ready_i=1 -> first 2 dropped; 12 outputs; sof_o on the first; eol_o on beats 4, 8 and 12; err_o=0.
REQ-040 SHALL cover: TDATA=48'h0102030405FF -> rgb_data_o[9:0]=10'h3FC, rgb_data_o[59:50]=10'h004, upper bits 0.
REQ-041 SHALL cover: TLAST on beat 2 of a line -> err_o=3'b001 for one cycle; the next beat counts as beat 0.
REQ-042 SHALL cover: beat 4 with TLAST=0 -> err_o=3'b010; eol_o=1 on that output word.
REQ-043 SHALL cover: TUSER at line 1 beat 2 -> err_o=3'b100; that word has sof_o=1 and its line restarts.
REQ-044 SHALL cover: rgb_ready_i=0 with continuous TVALID -> exactly 4 accepted then TREADY=0; raising rgb_ready_i drains in order with no loss or duplication.
